// File: rtl/sdram_test_pkg.sv
// Shared types, default widths and the pseudo-data pattern used by both the
// SDRAM DMA write test and the read-back checker.
package sdram_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_DATA_W    = 128;
    localparam int DEF_ADDR_W    = 28;
    localparam int DEF_BURST_W   = 8;
    localparam int DEF_MAX_BURST = 16;
    localparam int DEF_MAX_PEND  = 64;
    localparam int PAT_W         = 128;

    // {~idx, idx} with each half half_w bits wide; callers keep the low 2*half_w bits.
    function automatic logic [PAT_W-1:0] exp_word(input logic [31:0] idx, input int half_w);
        logic [63:0] w_mask;
        logic [63:0] w_lo;
        w_mask = ~64'd0 >> (64 - half_w);
        w_lo   = {32'd0, idx} & w_mask;
        return ({64'd0, ~w_lo & w_mask} << half_w) | {64'd0, w_lo};
    endfunction

endpackage

// File: rtl/sdram_rd_cmd_gen.sv
// Read command generator: burst sizing, command addressing, outstanding-word
// credit tracking and command hold while the slave stalls.
module sdram_rd_cmd_gen
    import sdram_test_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BURST_W   = DEF_BURST_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int MAX_PEND  = DEF_MAX_PEND
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [ADDR_W-1:0]  i_base,
    input  logic [31:0]        i_size,
    input  logic               i_active,
    input  logic               i_beat,
    input  logic               i_waitrequest,
    output logic [ADDR_W-1:0]  o_address,
    output logic [BURST_W-1:0] o_burstcount,
    output logic               o_read,
    output logic               o_req_done
);
    localparam int PEND_W = $clog2(MAX_PEND + 1);

    logic [ADDR_W-1:0]  r_base;
    logic [31:0]        r_req_words;
    logic [PEND_W-1:0]  r_pend;
    logic [31:0]        w_remain;
    logic [BURST_W-1:0] w_blen;
    logic               w_credit_ok;
    logic               w_accept;

    always_comb begin
        w_remain = i_size - r_req_words;
        if (w_remain > 32'(MAX_BURST)) begin
            w_blen = BURST_W'(MAX_BURST);
        end else begin
            w_blen = w_remain[BURST_W-1:0];
        end
    end

    // Command fields depend only on registers that move on acceptance, so they
    // hold by construction under waitrequest; returning beats only add credit.
    assign w_credit_ok  = (32'(r_pend) + 32'(w_blen)) <= 32'(MAX_PEND);
    assign o_read       = i_active && w_credit_ok;
    assign w_accept     = o_read && !i_waitrequest;
    assign o_address    = o_read ? (r_base + r_req_words[ADDR_W-1:0]) : '0;
    assign o_burstcount = o_read ? w_blen : '0;
    assign o_req_done   = w_accept && ((r_req_words + 32'(w_blen)) == i_size);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base      <= '0;
            r_req_words <= '0;
            r_pend      <= '0;
        end else if (i_load) begin
            r_base      <= i_base;
            r_req_words <= '0;
            r_pend      <= '0;
        end else begin
            if (w_accept) begin
                r_req_words <= r_req_words + 32'(w_blen);
            end
            r_pend <= r_pend + (w_accept ? PEND_W'(w_blen) : PEND_W'(0))
                             - (i_beat ? PEND_W'(1) : PEND_W'(0));
        end
    end

endmodule

// File: rtl/sdram_read_checker.sv
// Avalon-MM read-back checker: reads a buffer from SDRAM in pipelined bursts and
// compares each word against the DMA write-test pattern, collecting statistics.
module sdram_read_checker
    import sdram_test_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BURST_W   = DEF_BURST_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int MAX_PEND  = DEF_MAX_PEND
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [31:0]        base_addr_i,
    input  logic [31:0]        size_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [31:0]        err_cnt_o,
    output logic               first_err_valid_o,
    output logic [31:0]        first_err_idx_o,
    output logic [31:0]        cycle_cnt_o,
    output logic [ADDR_W-1:0]  avm_address_o,
    output logic [BURST_W-1:0] avm_burstcount_o,
    output logic               avm_read_o,
    input  logic               avm_waitrequest_i,
    input  logic [DATA_W-1:0]  avm_readdata_i,
    input  logic               avm_readdatavalid_i
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_size;
    logic [31:0]       r_rcv_words;
    logic [31:0]       r_err_cnt;
    logic [31:0]       r_first_idx;
    logic [31:0]       r_cycle_cnt;
    logic              r_first_valid;
    logic              r_done;
    logic              w_busy;
    logic              w_start_run;
    logic              w_start_zero;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_mismatch;
    logic              w_done_nxt;
    logic              w_req_done;
    logic [PAT_W-1:0]  w_exp_full;
    logic              w_unused_base;

    assign w_busy        = (r_state != IDLE);
    assign w_start_run   = start_i && !w_busy && (size_i != 32'd0);
    assign w_start_zero  = start_i && !w_busy && (size_i == 32'd0);
    assign w_beat        = avm_readdatavalid_i && w_busy;
    assign w_last_beat   = w_beat && ((r_rcv_words + 32'd1) == r_size);
    assign w_exp_full    = exp_word(r_rcv_words, DATA_W / 2);
    assign w_mismatch    = w_beat && (avm_readdata_i != w_exp_full[DATA_W-1:0]);
    assign w_unused_base = ^base_addr_i[31:ADDR_W];

    sdram_rd_cmd_gen #(
        .ADDR_W    (ADDR_W),
        .BURST_W   (BURST_W),
        .MAX_BURST (MAX_BURST),
        .MAX_PEND  (MAX_PEND)
    ) u_cmd_gen (
        .i_clk         (clk_i),
        .i_rst         (rst_i),
        .i_load        (w_start_run),
        .i_base        (base_addr_i[ADDR_W-1:0]),
        .i_size        (r_size),
        .i_active      (r_state == REQ),
        .i_beat        (w_beat),
        .i_waitrequest (avm_waitrequest_i),
        .o_address     (avm_address_o),
        .o_burstcount  (avm_burstcount_o),
        .o_read        (avm_read_o),
        .o_req_done    (w_req_done)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_run) begin
                    w_state_nxt = REQ;
                end else if (w_start_zero) begin
                    w_done_nxt = 1'b1;
                end
            end
            REQ: begin
                if (w_req_done) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_beat) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_done        <= 1'b0;
            r_size        <= '0;
            r_rcv_words   <= '0;
            r_err_cnt     <= '0;
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
            r_cycle_cnt   <= '0;
        end else begin
            r_done <= w_done_nxt;
            if (w_start_run) begin
                r_size        <= size_i;
                r_rcv_words   <= '0;
                r_err_cnt     <= '0;
                r_first_valid <= 1'b0;
                r_first_idx   <= '0;
                r_cycle_cnt   <= '0;
            end else begin
                if (w_busy) begin
                    r_cycle_cnt <= r_cycle_cnt + 32'd1;
                end
                if (w_beat) begin
                    r_rcv_words <= r_rcv_words + 32'd1;
                end
                if (w_mismatch) begin
                    if (r_err_cnt != 32'hFFFF_FFFF) begin
                        r_err_cnt <= r_err_cnt + 32'd1;
                    end
                    if (!r_first_valid) begin
                        r_first_valid <= 1'b1;
                        r_first_idx   <= r_rcv_words;
                    end
                end
            end
        end
    end

    assign busy_o            = w_busy;
    assign done_o            = r_done;
    assign err_cnt_o         = r_err_cnt;
    assign first_err_valid_o = r_first_valid;
    assign first_err_idx_o   = r_first_idx;
    assign cycle_cnt_o       = r_cycle_cnt;

endmodule

// File: tb/tb_sdram_read_checker.sv
// Directed and randomized bench for sdram_read_checker with a queue-based
// Avalon-MM slave and a word-level reference model of the expected results.
module tb_sdram_read_checker;
    localparam int DATA_W    = 128;
    localparam int ADDR_W    = 28;
    localparam int BURST_W   = 8;
    localparam int MAX_BURST = 16;
    localparam int MAX_PEND  = 16;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               start_i;
    logic [31:0]        base_addr_i;
    logic [31:0]        size_i;
    logic               busy_o;
    logic               done_o;
    logic [31:0]        err_cnt_o;
    logic               first_err_valid_o;
    logic [31:0]        first_err_idx_o;
    logic [31:0]        cycle_cnt_o;
    logic [ADDR_W-1:0]  avm_address_o;
    logic [BURST_W-1:0] avm_burstcount_o;
    logic               avm_read_o;
    logic               avm_waitrequest_i;
    logic [DATA_W-1:0]  avm_readdata_i;
    logic               avm_readdatavalid_i;

    sdram_read_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W),
        .MAX_BURST(MAX_BURST), .MAX_PEND(MAX_PEND)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .size_i(size_i),
        .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
        .first_err_valid_o(first_err_valid_o), .first_err_idx_o(first_err_idx_o),
        .cycle_cnt_o(cycle_cnt_o), .avm_address_o(avm_address_o),
        .avm_burstcount_o(avm_burstcount_o), .avm_read_o(avm_read_o),
        .avm_waitrequest_i(avm_waitrequest_i), .avm_readdata_i(avm_readdata_i),
        .avm_readdatavalid_i(avm_readdatavalid_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pcyc = 0;
    int ncyc = 0;
    int t_start = 0;

    always @(posedge clk) pcyc <= pcyc + 1;

    typedef struct {
        logic [31:0] idx;
        int          due;
    } beat_t;

    beat_t       bq[$];
    beat_t       cur_beat;
    logic [31:0] cmd_addr_q[$];
    int          cmd_len_q[$];
    bit          corrupt [0:255];
    logic [31:0] cur_base = '0;
    int          lat = 2;
    int          stall_left = 0;
    bit          stall_after_first = 1'b0;
    int          beats_allowed = 1 << 30;
    int          delivered = 0;
    int          first_cmd_cycles = 0;
    int          unstable = 0;
    int          credit_viol = 0;
    int          read_hi = 0;
    int          done_seen = 0;
    logic [ADDR_W-1:0]  stall_addr;
    logic [BURST_W-1:0] stall_len;

    // Slave: decides waitrequest/readdatavalid at the falling edge for the next rising edge.
    always @(negedge clk) begin
        ncyc++;
        if (done_o) done_seen++;
        if (avm_read_o) read_hi++;
        avm_readdatavalid_i = 1'b0;
        avm_readdata_i      = '0;
        if (bq.size() != 0 && bq[0].due <= ncyc && delivered < beats_allowed) begin
            cur_beat = bq.pop_front();
            avm_readdatavalid_i = 1'b1;
            avm_readdata_i = {~{32'd0, cur_beat.idx}, {32'd0, cur_beat.idx}}
                             ^ {127'd0, corrupt[cur_beat.idx[7:0]]};
            delivered++;
        end
        avm_waitrequest_i = 1'b0;
        if (avm_read_o) begin
            if (stall_after_first && cmd_addr_q.size() != 0) begin
                avm_waitrequest_i = 1'b1;
            end else if (stall_left > 0) begin
                avm_waitrequest_i = 1'b1;
                stall_left--;
            end
            if (cmd_addr_q.size() == 0) begin
                first_cmd_cycles++;
                if (first_cmd_cycles == 1) begin
                    stall_addr = avm_address_o;
                    stall_len  = avm_burstcount_o;
                end else if (avm_address_o != stall_addr || avm_burstcount_o != stall_len) begin
                    unstable++;
                end
            end
            if (!avm_waitrequest_i) begin
                if (bq.size() + int'(avm_readdatavalid_i) + int'(avm_burstcount_o) > MAX_PEND)
                    credit_viol++;
                cmd_addr_q.push_back(32'(avm_address_o));
                cmd_len_q.push_back(int'(avm_burstcount_o));
                for (int k = 0; k < int'(avm_burstcount_o); k++)
                    bq.push_back('{32'(avm_address_o) + 32'(k) - cur_base, ncyc + lat});
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, busy_o, 0);
        check({tag, " done"}, done_o, 0);
        check({tag, " err"}, err_cnt_o, 0);
        check({tag, " fev"}, first_err_valid_o, 0);
        check({tag, " fidx"}, first_err_idx_o, 0);
        check({tag, " cyc"}, cycle_cnt_o, 0);
        check({tag, " read"}, avm_read_o, 0);
        check({tag, " addr"}, avm_address_o, 0);
        check({tag, " burst"}, avm_burstcount_o, 0);
    endtask

    task automatic setup(input int l, input int stl);
        cmd_addr_q.delete();
        cmd_len_q.delete();
        first_cmd_cycles = 0;
        unstable = 0;
        credit_viol = 0;
        delivered = 0;
        beats_allowed = 1 << 30;
        lat = l;
        stall_left = stl;
    endtask

    task automatic clear_corrupt();
        for (int i = 0; i < 256; i++) corrupt[i] = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] b, input logic [31:0] s);
        @(negedge clk);
        base_addr_i = b;
        size_i      = s;
        cur_base    = b;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        t_start = pcyc;
    endtask

    task automatic wait_done(input string tag, output int e);
        for (int i = 0; i < 3000; i++) begin
            if (done_o) break;
            @(negedge clk);
        end
        check({tag, " done seen"}, done_o, 1);
        e = pcyc;
    endtask

    // Reference: word i is bad iff corrupted; commands tile [0,size) in MAX_BURST chunks.
    task automatic check_results(input string tag, input logic [31:0] b, input int s, input int e);
        int          n_err = 0;
        bit          fv = 1'b0;
        logic [31:0] fidx = '0;
        int          ncmd;
        logic [31:0] a;
        for (int i = 0; i < s; i++) begin
            if (corrupt[8'(i)]) begin
                n_err++;
                if (!fv) begin
                    fv = 1'b1;
                    fidx = 32'(i);
                end
            end
        end
        check({tag, " err"}, err_cnt_o, 64'(n_err));
        check({tag, " fev"}, first_err_valid_o, fv);
        check({tag, " fidx"}, first_err_idx_o, fidx);
        check({tag, " cyc"}, cycle_cnt_o, 64'(e - t_start));
        check({tag, " busy at done"}, busy_o, 0);
        ncmd = (s + MAX_BURST - 1) / MAX_BURST;
        check({tag, " ncmd"}, cmd_addr_q.size(), ncmd);
        if (cmd_addr_q.size() == ncmd) begin
            for (int k = 0; k < ncmd; k++) begin
                a = (b + 32'(k * MAX_BURST)) & 32'h0FFF_FFFF;
                check($sformatf("%s cmd%0d addr", tag, k), cmd_addr_q[k], a);
                check($sformatf("%s cmd%0d len", tag, k), cmd_len_q[k],
                      (s - k * MAX_BURST > MAX_BURST) ? MAX_BURST : s - k * MAX_BURST);
            end
        end
        check({tag, " credit"}, credit_viol, 0);
        @(negedge clk);
        check({tag, " done pulse"}, done_o, 0);
        check({tag, " err hold"}, err_cnt_o, 64'(n_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e;
        logic [31:0] rb;
        int          rs;
        rst_i = 1'b1;
        start_i = 1'b0;
        base_addr_i = '0;
        size_i = '0;
        avm_waitrequest_i = 1'b0;
        avm_readdata_i = '0;
        avm_readdatavalid_i = 1'b0;
        clear_corrupt();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_i = 1'b0;

        // Basic run and first-cycle timing
        setup(2, 0);
        start_run(32'h100, 4);
        check("basic busy T+1", busy_o, 1);
        check("basic read T+1", avm_read_o, 1);
        wait_done("basic", e);
        check_results("basic", 32'h100, 4, e);

        setup(2, 0);
        start_run(32'h100, 20);
        wait_done("split", e);
        check_results("split", 32'h100, 20, e);

        corrupt[5] = 1'b1;
        corrupt[9] = 1'b1;
        setup(3, 0);
        start_run(32'h100, 16);
        wait_done("corrupt", e);
        check_results("corrupt", 32'h100, 16, e);
        clear_corrupt();

        for (int r = 0; r < 4; r++) begin
            rb = 32'($urandom_range(0, 32'hF_FFFF));
            rs = int'($urandom_range(1, 60));
            for (int i = 0; i < rs; i++) corrupt[i] = ($urandom_range(0, 7) == 0);
            setup(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
            start_run(rb, 32'(rs));
            wait_done($sformatf("rand%0d", r), e);
            check_results($sformatf("rand%0d", r), rb, rs, e);
            clear_corrupt();
        end

        // Waitrequest hold on the first command
        setup(2, 3);
        start_run(32'h200, 16);
        wait_done("stall", e);
        check("stall read cycles", first_cmd_cycles, 4);
        check("stall stable", unstable, 0);
        check_results("stall", 32'h200, 16, e);

        // Credit limit with data withheld
        setup(2, 0);
        beats_allowed = 0;
        start_run(32'h300, 48);
        repeat (30) @(negedge clk);
        check("credit ncmd held", cmd_addr_q.size(), 1);
        check("credit read low", avm_read_o, 0);
        check("credit busy", busy_o, 1);
        beats_allowed = 1 << 30;
        wait_done("credit", e);
        check_results("credit", 32'h300, 48, e);

        // Zero size
        setup(2, 0);
        read_hi = 0;
        done_seen = 0;
        @(negedge clk);
        size_i = 0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("zero done T+1", done_o, 1);
        check("zero busy", busy_o, 0);
        @(negedge clk);
        check("zero done pulse", done_o, 0);
        repeat (8) @(negedge clk);
        check("zero no read", read_hi, 0);
        check("zero one done", done_seen, 1);

        // Start while busy is ignored
        setup(2, 0);
        start_run(32'h100, 20);
        repeat (3) @(negedge clk);
        base_addr_i = 32'h5000;
        size_i = 4;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("restart", e);
        check_results("restart", 32'h100, 20, e);

        // Reset mid-run with 8 beats outstanding; late beats carry bad data
        setup(2, 0);
        stall_after_first = 1'b1;
        beats_allowed = 8;
        for (int i = 8; i < 16; i++) corrupt[i] = 1'b1;
        start_run(32'h400, 24);
        for (int i = 0; i < 200; i++) begin
            if (delivered == 8) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("midrst busy", busy_o, 1);
        check("midrst read", avm_read_o, 1);
        #2 rst_i = 1'b1;
        #1 check_all_zero("midrst async");
        @(negedge clk);
        rst_i = 1'b0;
        stall_after_first = 1'b0;
        beats_allowed = 1 << 30;
        done_seen = 0;
        repeat (20) @(negedge clk);
        check("late err", err_cnt_o, 0);
        check("late fev", first_err_valid_o, 0);
        check("late busy", busy_o, 0);
        check("late done", done_seen, 0);
        clear_corrupt();
        setup(2, 0);
        start_run(32'h500, 4);
        wait_done("after rst", e);
        check_results("after rst", 32'h500, 4, e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
